tetris_board_dp: RTL and testbench

//   Parametrised Tetris board datapath. Spawns a piece, applies move commands with

---
 rtl/tetris_board_dp.sv | 225 ++++++++++++++++++++++
 tb/tb_tetris_board_dp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_board_dp.sv
// Tetris board datapath: spawn, move with collision checks, lock, then scan/clear full rows.
// Optional `TETRIS_SCORE_EN adds a 16-bit saturating score port.
module tetris_board_dp #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CNT_W = 8
) (
    input  logic                 clka,
    input  logic                 restart_n,
    input  logic                 start,
    input  logic [1:0]           piece_sel,
    input  logic                 move_valid,
    input  logic [1:0]           move,
    output logic                 move_ready,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [ROWS*COLS-1:0] frame_out,
    output logic [CNT_W-1:0]     lines_cleared,
    output logic                 done,
    output logic                 game_over,
`ifdef TETRIS_SCORE_EN
    output logic [15:0]          score,
`endif
    output logic [2:0]           state_o
);

    localparam int N  = ROWS * COLS;
    localparam int XW = $clog2(COLS) + 1;
    localparam int YW = $clog2(ROWS) + 1;
    localparam int RW = $clog2(ROWS);
    localparam logic [XW-1:0] SPAWN_X = XW'((COLS - 4) / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_SCAN  = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6,
        S_OVER  = 3'd7
    } state_t;

    state_t         state_q;
    logic [N-1:0]   board_q;
    logic [CNT_W-1:0] lines_q;
    logic           done_q;
    logic           over_q;
    logic [1:0]     sel_q;
    logic [XW-1:0]  px_q;
    logic [YW-1:0]  py_q;
    logic [RW-1:0]  row_q;

    logic [N-1:0]   cells_d;
    logic [N-1:0]   shifted_d;
    logic [N-1:0]   keep_mask;
    logic [N-1:0]   row_sh;
    logic           row_full;
    logic           hit_left, hit_right, hit_down, hit_spawn;

    function automatic logic [3:0] piece_row(input logic [1:0] sel, input logic bot);
        logic [3:0] m;
        case (sel)
            2'd0:    m = 4'b0011;
            2'd1:    m = bot ? 4'b0000 : 4'b1111;
            2'd2:    m = bot ? 4'b0011 : 4'b0110;
            default: m = bot ? 4'b0010 : 4'b0111;
        endcase
        return m;
    endfunction

    // A piece collides if any of its cells is off the board or overlaps a locked cell.
    function automatic logic hits(input logic [N-1:0] brd, input logic [1:0] sel,
                                  input int x, input int y);
        logic [3:0]   m;
        logic [N-1:0] sh;
        logic         hit;
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m = piece_row(sel, k == 1);
            for (int j = 0; j < 4; j++) begin
                if (m[0]) begin
                    if (x + j < 0 || x + j >= COLS || y + k >= ROWS) begin
                        hit = 1'b1;
                    end else begin
                        sh = brd >> ((y + k) * COLS + x + j);
                        if (sh[0]) hit = 1'b1;
                    end
                end
                m = m >> 1;
            end
        end
        return hit;
    endfunction

    function automatic logic [N-1:0] piece_cells(input logic [1:0] sel, input int x, input int y);
        logic [3:0]   m;
        logic [N-1:0] acc;
        acc = '0;
        for (int k = 0; k < 2; k++) begin
            m = piece_row(sel, k == 1);
            for (int j = 0; j < 4; j++) begin
                if (m[0] && x + j >= 0 && x + j < COLS && y + k < ROWS)
                    acc = acc | (N'(1) << ((y + k) * COLS + x + j));
                m = m >> 1;
            end
        end
        return acc;
    endfunction

    always_comb begin
        cells_d   = piece_cells(sel_q, int'(px_q), int'(py_q));
        hit_left  = hits(board_q, sel_q, int'(px_q) - 1, int'(py_q));
        hit_right = hits(board_q, sel_q, int'(px_q) + 1, int'(py_q));
        hit_down  = hits(board_q, sel_q, int'(px_q), int'(py_q) + 1);
        hit_spawn = hits(board_q, piece_sel, int'(SPAWN_X), 0);
        row_sh    = board_q >> (int'(row_q) * COLS);
        row_full  = &row_sh[COLS-1:0];
        // Rows 0..row_q take the row above them; rows below row_q keep their contents.
        keep_mask = {N{1'b1}} << ((int'(row_q) + 1) * COLS);
        shifted_d = ((board_q << COLS) & ~keep_mask) | (board_q & keep_mask);
    end

`ifdef TETRIS_SCORE_EN
    logic [15:0] score_q;
    logic [1:0]  clr_q;
    logic [15:0] score_add;
    logic [16:0] score_sum;
    always_comb begin
        score_add = (clr_q == 2'd0) ? 16'd0 : ((clr_q == 2'd1) ? 16'd1 : 16'd3);
        score_sum = {1'b0, score_q} + {1'b0, score_add};
    end
`endif

    // Handshake: a move is taken on a clka edge where move_valid && move_ready;
    // move_ready is high exactly while the FSM is in FALL, one move per cycle.
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state_q <= S_IDLE;
            board_q <= '0;
            lines_q <= '0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
            sel_q   <= 2'd0;
            px_q    <= '0;
            py_q    <= '0;
            row_q   <= '0;
`ifdef TETRIS_SCORE_EN
            score_q <= '0;
            clr_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) state_q <= S_SPAWN;
                S_SPAWN: begin
                    sel_q <= piece_sel;
                    px_q  <= SPAWN_X;
                    py_q  <= '0;
                    if (hit_spawn) begin
                        state_q <= S_OVER;
                        over_q  <= 1'b1;
                    end else begin
                        state_q <= S_FALL;
                    end
                end
                S_FALL: begin
                    if (move_valid) begin
                        case (move)
                            2'b01: if (px_q != '0 && !hit_left) px_q <= px_q - 1'b1;
                            2'b10: if (!hit_right) px_q <= px_q + 1'b1;
                            2'b11: begin
                                if (!hit_down) py_q <= py_q + 1'b1;
                                else state_q <= S_LOCK;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOCK: begin
                    board_q <= board_q | cells_d;
                    row_q   <= RW'(ROWS - 1);
                    state_q <= S_SCAN;
`ifdef TETRIS_SCORE_EN
                    clr_q   <= '0;
`endif
                end
                S_SCAN: begin
                    if (row_full) begin
                        state_q <= S_SHIFT;
                    end else if (row_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
`ifdef TETRIS_SCORE_EN
                        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    end else begin
                        row_q <= row_q - 1'b1;
                    end
                end
                S_SHIFT: begin
                    board_q <= shifted_d;
                    if (lines_q != '1) lines_q <= lines_q + 1'b1;
`ifdef TETRIS_SCORE_EN
                    if (clr_q != 2'b11) clr_q <= clr_q + 1'b1;
`endif
                    state_q <= S_SCAN;
                end
                S_DONE:  state_q <= S_IDLE;
                default: over_q  <= 1'b1;
            endcase
        end
    end

    assign move_ready    = (state_q == S_FALL);
    assign board_out     = board_q;
    assign frame_out     = (state_q == S_FALL) ? (board_q | cells_d) : board_q;
    assign lines_cleared = lines_q;
    assign done          = done_q;
    assign game_over     = over_q;
    assign state_o       = state_q;
`ifdef TETRIS_SCORE_EN
    assign score         = score_q;
`endif

endmodule

// File: tb/tb_tetris_board_dp.sv
// Directed bench for tetris_board_dp on an 8x6 board: scoreboard queues checked by a monitor.
module tb_tetris_board_dp;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CNT_W = 8;
  localparam int N = ROWS * COLS;

  logic clka = 1'b0;
  logic restart_n, start, move_valid;
  logic [1:0] piece_sel, move;
  logic move_ready, done, game_over;
  logic [N-1:0] board_out, frame_out;
  logic [CNT_W-1:0] lines_cleared;
  logic [2:0] state_o;
`ifdef TETRIS_SCORE_EN
  logic [15:0] score;
  logic [15:0] exp_score_q[$];
`endif

  logic [CNT_W+N-1:0] exp_q[$];
  logic [N-1:0] exp_frame_q[$];
  logic pend_mv = 1'b0;
  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clka = ~clka;

  tetris_board_dp #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clka(clka),
    .restart_n(restart_n),
    .start(start),
    .piece_sel(piece_sel),
    .move_valid(move_valid),
    .move(move),
    .move_ready(move_ready),
    .board_out(board_out),
    .frame_out(frame_out),
    .lines_cleared(lines_cleared),
    .done(done),
    .game_over(game_over),
`ifdef TETRIS_SCORE_EN
    .score(score),
`endif
    .state_o(state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // monitor: frame after each accepted move, board/lines on each done pulse
  initial begin
    forever begin
      @(negedge clka);
      if (pend_mv) begin
        if (exp_frame_q.size() == 0) flag("frame_unexpected");
        else check("frame", frame_out, exp_frame_q.pop_front());
      end
      pend_mv = move_valid && move_ready && restart_n;
      if (done) begin
        if (exp_q.size() == 0) flag("done_unexpected");
        else check("done_lines_board", {lines_cleared, board_out}, exp_q.pop_front());
`ifdef TETRIS_SCORE_EN
        if (exp_score_q.size() != 0) check("done_score", score, exp_score_q.pop_front());
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic spawn(input logic [1:0] sel);
    piece_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic do_move(input logic [1:0] m, input logic [N-1:0] exp_frame);
    exp_frame_q.push_back(exp_frame);
    move_valid = 1'b1;
    move = m;
    tick();
    move_valid = 1'b0;
    move = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (state_o == 3'd0) return;
      tick();
    end
    flag("idle_timeout");
  endtask

  task automatic lock(input logic [N-1:0] exp_frame, input logic [CNT_W-1:0] exp_lines,
                      input logic [N-1:0] exp_board, input logic [15:0] exp_score);
    exp_q.push_back({exp_lines, exp_board});
`ifdef TETRIS_SCORE_EN
    exp_score_q.push_back(exp_score);
`endif
    do_move(2'b11, exp_frame);
    wait_idle();
  endtask

  initial begin
    restart_n = 1'b0;
    start = 1'b0;
    move_valid = 1'b0;
    move = 2'b00;
    piece_sel = 2'd0;
    tick();
    tick();
    check("rst_board", board_out, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_done", done, 0);
    check("rst_over", game_over, 0);
    check("rst_ready", move_ready, 0);
    check("rst_state", state_o, 0);
`ifdef TETRIS_SCORE_EN
    check("rst_score", score, 0);
`endif
    restart_n = 1'b1;

    // O piece: spawn position, left wall, floor lock
    spawn(2'd0);
    check("spawn_state", state_o, 2);
    check("spawn_ready", move_ready, 1);
    check("spawn_frame", frame_out, 48'h000000000C0C);
    do_move(2'b01, 48'h000000000606);
    do_move(2'b01, 48'h000000000303);
    for (int i = 0; i < 8; i++) do_move(2'b01, 48'h000000000303);
    do_move(2'b11, 48'h000000030300);
    do_move(2'b11, 48'h000003030000);
    do_move(2'b11, 48'h000303000000);
    do_move(2'b11, 48'h030300000000);
    lock(48'h000000000000, 8'd0, 48'h030300000000, 16'd0);

    // O piece at px=4
    spawn(2'd0);
    do_move(2'b10, 48'h030300001818);
    do_move(2'b10, 48'h030300003030);
    do_move(2'b11, 48'h030300303000);
    do_move(2'b11, 48'h030330300000);
    do_move(2'b11, 48'h033330000000);
    do_move(2'b11, 48'h333300000000);
    lock(48'h030300000000, 8'd0, 48'h333300000000, 16'd0);

    // O piece at right wall, blocked right and blocked left by locked cells
    spawn(2'd0);
    do_move(2'b10, 48'h333300001818);
    do_move(2'b10, 48'h333300003030);
    do_move(2'b10, 48'h333300006060);
    do_move(2'b10, 48'h33330000C0C0);
    do_move(2'b10, 48'h33330000C0C0);
    do_move(2'b11, 48'h333300C0C000);
    do_move(2'b11, 48'h3333C0C00000);
    do_move(2'b11, 48'h33F3C0000000);
    do_move(2'b11, 48'hF3F300000000);
    do_move(2'b01, 48'hF3F300000000);
    lock(48'h333300000000, 8'd0, 48'hF3F300000000, 16'd0);

    // O piece completes rows 4 and 5: two rows cleared
    spawn(2'd0);
    do_move(2'b00, 48'hF3F300000C0C);
    do_move(2'b11, 48'hF3F3000C0C00);
    do_move(2'b11, 48'hF3F30C0C0000);
    do_move(2'b11, 48'hF3FF0C000000);
    do_move(2'b11, 48'hFFFF00000000);
    lock(48'hF3F300000000, 8'd2, 48'h000000000000, 16'd3);

    // stack column 2..3 to the top, then spawn collides
    spawn(2'd0);
    do_move(2'b11, 48'h0000000C0C00);
    do_move(2'b11, 48'h00000C0C0000);
    do_move(2'b11, 48'h000C0C000000);
    do_move(2'b11, 48'h0C0C00000000);
    lock(48'h000000000000, 8'd2, 48'h0C0C00000000, 16'd3);
    spawn(2'd0);
    do_move(2'b11, 48'h0C0C000C0C00);
    do_move(2'b11, 48'h0C0C0C0C0000);
    lock(48'h0C0C00000000, 8'd2, 48'h0C0C0C0C0000, 16'd3);
    spawn(2'd0);
    lock(48'h0C0C0C0C0000, 8'd2, 48'h0C0C0C0C0C0C, 16'd3);
    spawn(2'd1);
    check("over_flag", game_over, 1);
    check("over_ready", move_ready, 0);
    check("over_state", state_o, 7);
    check("over_frame", frame_out, 48'h0C0C0C0C0C0C);
    move_valid = 1'b1;
    move = 2'b11;
    start = 1'b1;
    repeat (3) tick();
    move_valid = 1'b0;
    start = 1'b0;
    check("over_sticky", game_over, 1);
    check("over_hold_state", state_o, 7);
    check("over_board_frozen", board_out, 48'h0C0C0C0C0C0C);
    check("over_lines", lines_cleared, 2);

    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
    check("rst2_board", board_out, 0);
    check("rst2_lines", lines_cleared, 0);
    check("rst2_over", game_over, 0);
    check("rst2_state", state_o, 0);

    // two I pieces fill row 5; reset lands during the SHIFT
    spawn(2'd1);
    check("i_spawn_frame", frame_out, 48'h00000000003C);
    do_move(2'b01, 48'h00000000001E);
    do_move(2'b01, 48'h00000000000F);
    do_move(2'b11, 48'h000000000F00);
    do_move(2'b11, 48'h0000000F0000);
    do_move(2'b11, 48'h00000F000000);
    do_move(2'b11, 48'h000F00000000);
    do_move(2'b11, 48'h0F0000000000);
    lock(48'h000000000000, 8'd0, 48'h0F0000000000, 16'd0);
    spawn(2'd1);
    do_move(2'b10, 48'h0F0000000078);
    do_move(2'b10, 48'h0F00000000F0);
    do_move(2'b11, 48'h0F000000F000);
    do_move(2'b11, 48'h0F0000F00000);
    do_move(2'b11, 48'h0F00F0000000);
    do_move(2'b11, 48'h0FF000000000);
    do_move(2'b11, 48'hFF0000000000);
    do_move(2'b11, 48'h0F0000000000);
    begin
      bit hit_shift;
      hit_shift = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (state_o == 3'd5) begin
          hit_shift = 1'b1;
          break;
        end
        tick();
      end
      if (!hit_shift) flag("shift_timeout");
    end
    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
    check("shift_rst_board", board_out, 0);
    check("shift_rst_lines", lines_cleared, 0);
    check("shift_rst_state", state_o, 0);
    check("shift_rst_done", done, 0);
`ifdef TETRIS_SCORE_EN
    check("shift_rst_score", score, 0);
`endif

    repeat (3) tick();
    check("done_queue_drained", exp_q.size(), 0);
    check("frame_queue_drained", exp_frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
